// File: rtl/instruction_fetch_unit_pkg.sv
// Shared pipeline definitions for the fetch stage: NOP encoding, default reset PC
// and the IF/ID bundle layout handed to the decode stage.
package instruction_fetch_unit_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{valid: 1'b0, instr: NOP, pc: 32'h0000_0000, pc_plus4: 32'h0000_0000};

endpackage

// File: rtl/instruction_fetch_unit_if_id_register.sv
// IF/ID pipeline register: captures a fetched bundle, holds it, or loads a bubble.
// Bubble load wins over hold so a redirect is never swallowed by a stall.
module if_id_register
    import instruction_fetch_unit_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   hold,
    input  logic   load_bubble,
    input  if_id_t bundle_in,
    output if_id_t bundle_out
);

    if_id_t bundle_d;
    if_id_t bundle_q;

    // Next-state select between bubble, hold and capture.
    always_comb begin
        bundle_d = bundle_q;
        if (load_bubble) begin
            bundle_d = IF_ID_BUBBLE;
        end else if (hold) begin
            bundle_d = bundle_q;
        end else begin
            bundle_d = bundle_in;
        end
    end

    // Pipeline register with synchronous reset to a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            bundle_q <= IF_ID_BUBBLE;
        end else begin
            bundle_q <= bundle_d;
        end
    end

    assign bundle_out = bundle_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, addresses the zero-wait instruction ROM, and feeds the
// IF/ID register while handling redirect, flush and stall plus fault/perf tracking.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          IMEM_WORDS = 1024,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_instr,
    input  logic             stall,
    input  logic             flush,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_target,
    output logic             if_id_valid,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc,
    output logic [31:0]      if_id_pc_plus4,
    output logic             fetch_fault,
    output logic [CNT_W-1:0] fetch_count,
    output logic [CNT_W-1:0] bubble_count
);

    // Compared in 33 bits so a 4 GiB ROM does not overflow the limit.
    localparam logic [32:0] IMEM_BYTES = 33'(4 * IMEM_WORDS);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + CNT_W'(1);
    endfunction

    logic [31:0]      pc_d, pc_q;
    logic             fault_d, fault_q;
    logic [CNT_W-1:0] fetch_cnt_d, fetch_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
    logic             capture_s;
    logic             bubble_s;
    logic             pc_bad_s;
    logic             target_bad_s;
    logic [31:0]      pc_plus4_s;
    if_id_t           fetch_bundle_s;
    if_id_t           if_id_bundle_s;

    assign pc_plus4_s   = pc_q + 32'd4;
    assign pc_bad_s     = (pc_q[1:0] != 2'b00) || ({1'b0, pc_q} >= IMEM_BYTES);
    assign target_bad_s = (redirect_target[1:0] != 2'b00) || ({1'b0, redirect_target} >= IMEM_BYTES);

    // PC, fault and counter next-state; priority redirect > flush > stall > advance.
    always_comb begin
        pc_d         = pc_q;
        fault_d      = fault_q;
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        capture_s    = 1'b0;
        bubble_s     = 1'b0;
        if (redirect_valid) begin
            pc_d         = {redirect_target[31:2], 2'b00};
            bubble_s     = 1'b1;
            bubble_cnt_d = sat_inc(bubble_cnt_q);
            fault_d      = fault_q | target_bad_s;
        end else if (flush) begin
            pc_d         = pc_plus4_s;
            bubble_s     = 1'b1;
            bubble_cnt_d = sat_inc(bubble_cnt_q);
        end else if (stall) begin
            pc_d = pc_q;
        end else if (pc_bad_s) begin
            pc_d         = pc_plus4_s;
            bubble_s     = 1'b1;
            bubble_cnt_d = sat_inc(bubble_cnt_q);
            fault_d      = 1'b1;
        end else begin
            pc_d        = pc_plus4_s;
            capture_s   = 1'b1;
            fetch_cnt_d = sat_inc(fetch_cnt_q);
        end
    end

    // Fetch-stage state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            fault_q      <= 1'b0;
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            pc_q         <= pc_d;
            fault_q      <= fault_d;
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign fetch_bundle_s = '{valid: 1'b1, instr: imem_instr, pc: pc_q, pc_plus4: pc_plus4_s};

    if_id_register u_if_id_register (
        .clk         (clk),
        .reset       (reset),
        .hold        (!capture_s),
        .load_bubble (bubble_s),
        .bundle_in   (fetch_bundle_s),
        .bundle_out  (if_id_bundle_s)
    );

    assign imem_addr      = pc_q;
    assign if_id_valid    = if_id_bundle_s.valid;
    assign if_id_instr    = if_id_bundle_s.instr;
    assign if_id_pc       = if_id_bundle_s.pc;
    assign if_id_pc_plus4 = if_id_bundle_s.pc_plus4;
    assign fetch_fault    = fault_q;
    assign fetch_count    = fetch_cnt_q;
    assign bubble_count   = bubble_cnt_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit; ROM model returns word[k] = k.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic        fetch_fault;
    logic [31:0] fetch_count;
    logic [31:0] bubble_count;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    assign imem_instr = imem_addr >> 2;

    instruction_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_WORDS (1024),
        .CNT_W      (32)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .stall           (stall),
        .flush           (flush),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .if_id_valid     (if_id_valid),
        .if_id_instr     (if_id_instr),
        .if_id_pc        (if_id_pc),
        .if_id_pc_plus4  (if_id_pc_plus4),
        .fetch_fault     (fetch_fault),
        .fetch_count     (fetch_count),
        .bubble_count    (bubble_count)
    );

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        redirect_valid = 1'b0; redirect_target = 32'h0;
        step(3);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (if_id_valid !== 1'b0) $display("FAIL rst_valid got %0b exp 0", if_id_valid); else passes++;
        checks++; if (if_id_instr !== 32'h0) $display("FAIL rst_instr got %h exp 00000000", if_id_instr); else passes++;
        checks++; if ({if_id_pc, if_id_pc_plus4} !== 64'h0) $display("FAIL rst_pcs got %h/%h exp 0/0", if_id_pc, if_id_pc_plus4); else passes++;
        checks++; if (imem_addr !== 32'h0) $display("FAIL rst_addr got %h exp 00000000", imem_addr); else passes++;
        checks++; if ({fetch_fault, fetch_count, bubble_count} !== 65'h0) $display("FAIL rst_cnt got %0b %0d %0d exp 0 0 0", fetch_fault, fetch_count, bubble_count); else passes++;
    endtask

    task automatic test_sequential_fetch();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step(1);
            checks++;
            if (if_id_valid !== 1'b1 || if_id_pc !== 32'(4 * k) || if_id_instr !== 32'(k) || if_id_pc_plus4 !== 32'(4 * k + 4))
                $display("FAIL seq_%0d got v=%0b pc=%h instr=%h p4=%h exp v=1 pc=%h instr=%h", k, if_id_valid, if_id_pc, if_id_instr, if_id_pc_plus4, 32'(4 * k), 32'(k));
            else passes++;
        end
        checks++; if (fetch_count !== 32'd3) $display("FAIL seq_count got %0d exp 3", fetch_count); else passes++;
        checks++; if (imem_addr !== 32'd12) $display("FAIL seq_addr got %h exp 0000000c", imem_addr); else passes++;
    endtask

    task automatic test_stall();
        do_reset();
        step(2);
        stall = 1'b1;
        step(2);
        checks++; if (imem_addr !== 32'd8) $display("FAIL stall_pc got %h exp 00000008", imem_addr); else passes++;
        checks++; if (if_id_instr !== 32'd1 || if_id_pc !== 32'd4 || if_id_valid !== 1'b1) $display("FAIL stall_hold got instr=%h pc=%h exp 1/4", if_id_instr, if_id_pc); else passes++;
        checks++; if (fetch_count !== 32'd2 || bubble_count !== 32'd0) $display("FAIL stall_cnt got %0d/%0d exp 2/0", fetch_count, bubble_count); else passes++;
        stall = 1'b0;
        step(1);
        checks++; if (if_id_instr !== 32'd2 || if_id_pc !== 32'd8) $display("FAIL stall_resume got instr=%h pc=%h exp 2/8", if_id_instr, if_id_pc); else passes++;
    endtask

    task automatic test_redirect_over_stall();
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h40;
        step(1);
        stall = 1'b0; redirect_valid = 1'b0;
        checks++; if (imem_addr !== 32'h40) $display("FAIL redir_pc got %h exp 00000040", imem_addr); else passes++;
        checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0) $display("FAIL redir_bubble got v=%0b instr=%h exp 0/0", if_id_valid, if_id_instr); else passes++;
        checks++; if (bubble_count !== 32'd1) $display("FAIL redir_bcnt got %0d exp 1", bubble_count); else passes++;
        step(1);
        checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h40 || if_id_instr !== 32'd16 || if_id_pc_plus4 !== 32'h44)
            $display("FAIL redir_fetch got v=%0b pc=%h instr=%h p4=%h exp 1/40/10/44", if_id_valid, if_id_pc, if_id_instr, if_id_pc_plus4); else passes++;
        checks++; if (fetch_fault !== 1'b0) $display("FAIL redir_nofault got %0b exp 0", fetch_fault); else passes++;
    endtask

    task automatic test_flush();
        do_reset();
        step(4);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc !== 32'h0) $display("FAIL flush_bubble got v=%0b instr=%h pc=%h exp 0/0/0", if_id_valid, if_id_instr, if_id_pc); else passes++;
        checks++; if (imem_addr !== 32'h14) $display("FAIL flush_pc got %h exp 00000014", imem_addr); else passes++;
        checks++; if (fetch_fault !== 1'b0 || bubble_count !== 32'd1 || fetch_count !== 32'd4) $display("FAIL flush_cnt got f=%0b b=%0d c=%0d exp 0/1/4", fetch_fault, bubble_count, fetch_count); else passes++;
        flush = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h80;
        step(1);
        flush = 1'b0; redirect_valid = 1'b0;
        checks++; if (imem_addr !== 32'h80 || bubble_count !== 32'd2) $display("FAIL flush_vs_redir got pc=%h b=%0d exp 80/2", imem_addr, bubble_count); else passes++;
    endtask

    task automatic test_misaligned_redirect();
        int sticky_bad;
        do_reset();
        redirect_valid = 1'b1; redirect_target = 32'h42;
        step(1);
        redirect_valid = 1'b0;
        checks++; if (imem_addr !== 32'h40 || fetch_fault !== 1'b1) $display("FAIL misalign got pc=%h fault=%0b exp 40/1", imem_addr, fetch_fault); else passes++;
        sticky_bad = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (fetch_fault !== 1'b1) sticky_bad++;
        end
        checks++; if (sticky_bad != 0) $display("FAIL fault_sticky got %0d cycles clear exp 0", sticky_bad); else passes++;
        checks++; if (if_id_instr !== 32'd25) $display("FAIL misalign_run got instr=%h exp 00000019", if_id_instr); else passes++;
        do_reset();
        checks++; if (fetch_fault !== 1'b0) $display("FAIL fault_reset got %0b exp 0", fetch_fault); else passes++;
        redirect_valid = 1'b1; redirect_target = 32'h2000;
        step(1);
        redirect_valid = 1'b0;
        checks++; if (fetch_fault !== 1'b1 || imem_addr !== 32'h2000) $display("FAIL oor_target got fault=%0b pc=%h exp 1/2000", fetch_fault, imem_addr); else passes++;
    endtask

    task automatic test_end_of_rom();
        do_reset();
        redirect_valid = 1'b1; redirect_target = 32'hFF8;
        step(1);
        redirect_valid = 1'b0;
        step(2);
        checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'hFFC || if_id_instr !== 32'd1023 || fetch_fault !== 1'b0)
            $display("FAIL last_word got v=%0b pc=%h instr=%h fault=%0b exp 1/ffc/3ff/0", if_id_valid, if_id_pc, if_id_instr, fetch_fault); else passes++;
        step(1);
        checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || fetch_fault !== 1'b1)
            $display("FAIL past_end got v=%0b instr=%h fault=%0b exp 0/0/1", if_id_valid, if_id_instr, fetch_fault); else passes++;
        checks++; if (imem_addr !== 32'h1004 || bubble_count !== 32'd2 || fetch_count !== 32'd2)
            $display("FAIL past_end_cnt got pc=%h b=%0d c=%0d exp 1004/2/2", imem_addr, bubble_count, fetch_count); else passes++;
        stall = 1'b1;
        step(1);
        reset = 1'b1;
        step(1);
        reset = 1'b0; stall = 1'b0;
        checks++; if (imem_addr !== 32'h0 || if_id_valid !== 1'b0 || if_id_pc !== 32'h0 || if_id_pc_plus4 !== 32'h0)
            $display("FAIL rst_mid_stall got pc=%h v=%0b ipc=%h p4=%h exp all 0", imem_addr, if_id_valid, if_id_pc, if_id_pc_plus4); else passes++;
        checks++; if (fetch_fault !== 1'b0 || fetch_count !== 32'd0 || bubble_count !== 32'd0)
            $display("FAIL rst_mid_stall_cnt got f=%0b c=%0d b=%0d exp 0/0/0", fetch_fault, fetch_count, bubble_count); else passes++;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        redirect_valid = 1'b0; redirect_target = 32'h0;
        test_reset();
        test_sequential_fetch();
        test_stall();
        test_redirect_over_stall();
        test_flush();
        test_misaligned_redirect();
        test_end_of_rom();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
